// File: rtl/xform_pkg.sv
// Shared types and defaults for the affine-transform stream sequencer.
package xform_pkg;

  localparam int unsigned DataWidthDef = 16;
  localparam int unsigned OutWidthDef  = 16;
  localparam int unsigned LanesDef     = 4;
  localparam int unsigned MatRowsDef   = 3;
  localparam int unsigned PipeLatDef   = 4;
  localparam int unsigned CntWidthDef  = 16;

  // StMat: loading matrix rows, StRun: streaming vectors, StDrain: flushing the pipeline
  typedef enum logic [1:0] {
    StMat,
    StRun,
    StDrain
  } xform_state_e;

  // Extract lane idx of a beat packed with lane 0 in the low bits.
  function automatic logic [DataWidthDef-1:0] lane_slice(
    input logic [LanesDef*DataWidthDef-1:0] beat,
    input int unsigned                      idx
  );
    return beat[idx*DataWidthDef +: DataWidthDef];
  endfunction

endpackage

// File: rtl/xform_tag_pipe.sv
// Valid/last tag shift register that tracks vectors through the datapath latency.
module xform_tag_pipe #(
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic             last_i,
  output logic [Depth-1:0] vld_o,
  output logic [Depth-1:0] last_o,
  output logic             empty_next_o
);

  logic [Depth-1:0] vld_q, vld_d;
  logic [Depth-1:0] last_q, last_d;

  // Shift one stage per enabled cycle; hold everything while stalled.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    if (en_i) begin
      vld_d[0]  = vld_i;
      last_d[0] = last_i;
      for (int i = 1; i < int'(Depth); i++) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
      end
    end
  end

  // Tag state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign vld_o        = vld_q;
  assign last_o       = last_q;
  // Lets the sequencer leave drain in the same cycle the final result is taken.
  assign empty_next_o = ~|vld_d;

endmodule

// File: rtl/xform_stream_ctrl.sv
// Frame parser and stall controller for the 4-lane affine-transform datapath.
module xform_stream_ctrl
  import xform_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned OUT_WIDTH  = OutWidthDef,
  parameter int unsigned LANES      = LanesDef,
  parameter int unsigned MAT_ROWS   = MatRowsDef,
  parameter int unsigned PIPE_LAT   = PipeLatDef,
  parameter int unsigned CNT_WIDTH  = CntWidthDef
) (
  input  logic                        s00_axis_aclk,
  input  logic                        s00_axis_aresetn,
  input  logic [LANES*DATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic                        s_tlast,
  output logic                        cfg_we,
  output logic [1:0]                  cfg_row,
  output logic [LANES*DATA_WIDTH-1:0] cfg_data,
  output logic                        dp_ce,
  output logic                        dp_in_valid,
  output logic [LANES*DATA_WIDTH-1:0] dp_in_data,
  input  logic [LANES*OUT_WIDTH-1:0]  dp_out_data,
  output logic [LANES*OUT_WIDTH-1:0]  m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic                        busy,
  output logic                        err_hdr,
  output logic [CNT_WIDTH-1:0]        vec_count
);

  localparam logic [1:0] LastRow = 2'(MAT_ROWS - 1);

  xform_state_e                state_q, state_d;
  logic [1:0]                  row_cnt_q, row_cnt_d;
  logic                        cfg_we_q, cfg_we_d;
  logic [1:0]                  cfg_row_q, cfg_row_d;
  logic [LANES*DATA_WIDTH-1:0] cfg_data_q, cfg_data_d;
  logic                        err_hdr_q, err_hdr_d;
  logic [CNT_WIDTH-1:0]        vec_count_q, vec_count_d;

  logic [PIPE_LAT-1:0] vld, last;
  logic                pipe_empty_next;
  logic                accept;
  logic                vec_in;

  // Only a full output stage that is not being drained can stall the pipeline.
  assign dp_ce  = m_tready | ~vld[PIPE_LAT-1];
  assign accept = s_tvalid & s_tready;
  assign vec_in = (state_q == StRun) & accept;

  // Input ready depends on phase; never ready while reset is held.
  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      StMat:   s_tready = 1'b1;
      StRun:   s_tready = dp_ce;
      default: s_tready = 1'b0;
    endcase
    if (!s00_axis_aresetn) s_tready = 1'b0;
  end

  xform_tag_pipe #(
    .Depth(PIPE_LAT)
  ) u_tag_pipe (
    .clk_i       (s00_axis_aclk),
    .rst_ni      (s00_axis_aresetn),
    .en_i        (dp_ce),
    .vld_i       (vec_in),
    .last_i      (vec_in & s_tlast),
    .vld_o       (vld),
    .last_o      (last),
    .empty_next_o(pipe_empty_next)
  );

  // Frame parsing: header rows, vector stream, then drain before the next header.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    cfg_we_d    = 1'b0;
    cfg_row_d   = cfg_row_q;
    cfg_data_d  = cfg_data_q;
    err_hdr_d   = err_hdr_q;
    vec_count_d = vec_count_q;
    case (state_q)
      StMat: begin
        if (accept) begin
          if (s_tlast) begin
            // Truncated header: drop this beat, keep rows already written.
            err_hdr_d = 1'b1;
            row_cnt_d = '0;
          end else begin
            cfg_we_d   = 1'b1;
            cfg_row_d  = row_cnt_q;
            cfg_data_d = s_tdata;
            if (row_cnt_q == LastRow) begin
              row_cnt_d   = '0;
              vec_count_d = '0;
              state_d     = StRun;
            end else begin
              row_cnt_d = row_cnt_q + 2'd1;
            end
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (vec_count_q != '1) vec_count_d = vec_count_q + CNT_WIDTH'(1);
          if (s_tlast) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pipe_empty_next) state_d = StMat;
      end
      default: state_d = StMat;
    endcase
  end

  // Sequencer state and registered configuration outputs.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= StMat;
      row_cnt_q   <= '0;
      cfg_we_q    <= 1'b0;
      cfg_row_q   <= '0;
      cfg_data_q  <= '0;
      err_hdr_q   <= 1'b0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      cfg_we_q    <= cfg_we_d;
      cfg_row_q   <= cfg_row_d;
      cfg_data_q  <= cfg_data_d;
      err_hdr_q   <= err_hdr_d;
      vec_count_q <= vec_count_d;
    end
  end

  assign cfg_we      = cfg_we_q;
  assign cfg_row     = cfg_row_q;
  assign cfg_data    = cfg_data_q;
  assign err_hdr     = err_hdr_q;
  assign vec_count   = vec_count_q;
  assign dp_in_valid = vec_in;
  assign dp_in_data  = s_tdata;
  assign m_tdata     = dp_out_data;
  assign m_tvalid    = vld[PIPE_LAT-1];
  assign m_tlast     = last[PIPE_LAT-1];
  assign busy        = (state_q != StMat) | (|vld);

endmodule

// File: tb/tb_xform_stream_ctrl.sv
// Bench for xform_stream_ctrl: directed cycle table, hand sequences, randomized frames.
module tb_xform_stream_ctrl;
  import xform_pkg::*;

  localparam int unsigned PipeLat   = 4;
  localparam int unsigned MaxCycles = 20000;

  localparam logic [63:0] H0 = {16'hB000, 16'h0000, 16'h0000, 16'h0029};
  localparam logic [63:0] H1 = {16'hC000, 16'h0000, 16'h0029, 16'h0000};
  localparam logic [63:0] H2 = {16'hBB33, 16'h0029, 16'h0000, 16'h0000};
  localparam logic [63:0] HA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] HB = 64'h5555_6666_7777_8888;
  localparam logic [63:0] HC = 64'h0102_0304_0506_0708;
  localparam logic [63:0] HD = 64'h1020_3040_5060_7080;
  localparam logic [63:0] HE = 64'hA0B0_C0D0_E0F0_0011;
  localparam logic [63:0] W0 = 64'h0001_0033_0022_0011;
  localparam logic [63:0] W1 = 64'h0001_0066_0055_0044;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic        cfg_we;
  logic [1:0]  cfg_row;
  logic [63:0] cfg_data;
  logic        dp_ce, dp_in_valid;
  logic [63:0] dp_in_data, dp_out_data, m_tdata;
  logic        m_tvalid, m_tready, m_tlast, busy, err_hdr;
  logic [15:0] vec_count;

  always #5 clk = ~clk;

  xform_stream_ctrl #(
    .PIPE_LAT(PipeLat)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .s_tlast         (s_tlast),
    .cfg_we          (cfg_we),
    .cfg_row         (cfg_row),
    .cfg_data        (cfg_data),
    .dp_ce           (dp_ce),
    .dp_in_valid     (dp_in_valid),
    .dp_in_data      (dp_in_data),
    .dp_out_data     (dp_out_data),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .busy            (busy),
    .err_hdr         (err_hdr),
    .vec_count       (vec_count)
  );

  // Datapath stand-in: PipeLat enabled stages, result is the bitwise inverse of the vector.
  logic [63:0] dp_pipe [PipeLat];
  always @(posedge clk) begin
    if (dp_ce) begin
      dp_pipe[0] <= dp_in_data;
      for (int i = 1; i < int'(PipeLat); i++) dp_pipe[i] <= dp_pipe[i-1];
    end
  end
  assign dp_out_data = ~dp_pipe[PipeLat-1];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int l, input logic [63:0] d, input int r);
    @(negedge clk);
    s_tvalid = (v != 0);
    s_tlast  = (l != 0);
    s_tdata  = d;
    m_tready = (r != 0);
    #1;
  endtask

  function automatic logic [63:0] vec(input int k);
    return {16'd1, 16'(300 + k), 16'(200 + k), 16'(100 + k)};
  endfunction

  typedef struct {
    logic        v, l;
    logic [63:0] d;
    logic        e_srdy, e_dpv, e_we;
    logic [1:0]  e_row;
    logic [63:0] e_cfg;
    logic        e_mv, e_ml;
    logic [63:0] e_md;
    logic        e_busy;
    logic [15:0] e_vc;
  } vec_t;

  function automatic vec_t mk(input int v, input int l, input logic [63:0] d, input int srdy,
                              input int dpv, input int we, input int row, input logic [63:0] cfg,
                              input int mv, input int ml, input logic [63:0] md, input int bsy,
                              input int vc);
    vec_t t;
    t.v = (v != 0); t.l = (l != 0); t.d = d;
    t.e_srdy = (srdy != 0); t.e_dpv = (dpv != 0); t.e_we = (we != 0);
    t.e_row = 2'(row); t.e_cfg = cfg;
    t.e_mv = (mv != 0); t.e_ml = (ml != 0); t.e_md = md;
    t.e_busy = (bsy != 0); t.e_vc = 16'(vc);
    return t;
  endfunction

  // Randomized-phase reference: expectations built directly from the generated frames.
  typedef struct {logic [63:0] data; logic last; logic is_vec;} beat_t;
  typedef struct {logic [1:0] row; logic [63:0] data;} cfg_t;
  beat_t       beats[$];
  cfg_t        exp_cfg[$];
  logic [64:0] exp_res[$];
  logic        exp_err;
  int          exp_vc;

  logic        mon_en = 1'b0;
  logic        drv_is_vec = 1'b0;
  logic        hold_pend = 1'b0;
  logic [63:0] hold_data;
  int          outstanding = 0;
  cfg_t        mon_c;
  logic [64:0] mon_r;

  // Scoreboard: coefficient writes, result order/content, stall stability, idle-pipe writes.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      if (cfg_we) begin
        check("cfg_write_while_inflight", 72'(outstanding), 72'(0));
        check("cfg_write_expected", 72'(exp_cfg.size() != 0), 72'(1));
        if (exp_cfg.size() != 0) begin
          mon_c = exp_cfg.pop_front();
          check("cfg_write", 72'({cfg_row, cfg_data}), 72'({mon_c.row, mon_c.data}));
        end
      end
      if (hold_pend) check("result_hold", 72'({m_tvalid, m_tdata}), 72'({1'b1, hold_data}));
      hold_pend = m_tvalid & ~m_tready;
      hold_data = m_tdata;
      if (m_tvalid && m_tready) begin
        outstanding--;
        check("result_expected", 72'(exp_res.size() != 0), 72'(1));
        if (exp_res.size() != 0) begin
          mon_r = exp_res.pop_front();
          check("result", 72'({m_tlast, m_tdata}), 72'(mon_r));
        end
      end
      if (s_tvalid && s_tready && drv_is_vec) outstanding++;
    end else begin
      hold_pend   = 1'b0;
      outstanding = 0;
    end
  end

  vec_t tbl [13];

  initial begin
    int cyc;
    int k_hdr;
    int n_vec;
    logic [63:0] d;
    logic bad;

    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b1; rst_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst s_tready", 72'(s_tready), 72'(0));
    check("rst m_tvalid", 72'(m_tvalid), 72'(0));
    check("rst m_tlast", 72'(m_tlast), 72'(0));
    check("rst cfg", 72'({cfg_we, cfg_row, cfg_data}), 72'(0));
    check("rst busy", 72'(busy), 72'(0));
    check("rst err_hdr", 72'(err_hdr), 72'(0));
    check("rst vec_count", 72'(vec_count), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Header load then a 5-vector frame, cycle by cycle.
    tbl[0]  = mk(1, 0, H0,     1, 0, 0, 0, '0, 0, 0, '0,      0, 0);
    tbl[1]  = mk(1, 0, H1,     1, 0, 1, 0, H0, 0, 0, '0,      0, 0);
    tbl[2]  = mk(1, 0, H2,     1, 0, 1, 1, H1, 0, 0, '0,      0, 0);
    tbl[3]  = mk(1, 0, vec(0), 1, 1, 1, 2, H2, 0, 0, '0,      1, 0);
    tbl[4]  = mk(1, 0, vec(1), 1, 1, 0, 0, '0, 0, 0, '0,      1, 1);
    tbl[5]  = mk(1, 0, vec(2), 1, 1, 0, 0, '0, 0, 0, '0,      1, 2);
    tbl[6]  = mk(1, 0, vec(3), 1, 1, 0, 0, '0, 0, 0, '0,      1, 3);
    tbl[7]  = mk(1, 1, vec(4), 1, 1, 0, 0, '0, 1, 0, ~vec(0), 1, 4);
    tbl[8]  = mk(0, 0, '0,     0, 0, 0, 0, '0, 1, 0, ~vec(1), 1, 5);
    tbl[9]  = mk(0, 0, '0,     0, 0, 0, 0, '0, 1, 0, ~vec(2), 1, 5);
    tbl[10] = mk(0, 0, '0,     0, 0, 0, 0, '0, 1, 0, ~vec(3), 1, 5);
    tbl[11] = mk(0, 0, '0,     0, 0, 0, 0, '0, 1, 1, ~vec(4), 1, 5);
    tbl[12] = mk(0, 0, '0,     1, 0, 0, 0, '0, 0, 0, '0,      0, 5);
    for (int k = 0; k < 13; k++) begin
      drive(int'(tbl[k].v), int'(tbl[k].l), tbl[k].d, 1);
      check($sformatf("tbl%0d s_tready", k), 72'(s_tready), 72'(tbl[k].e_srdy));
      check($sformatf("tbl%0d dp_in_valid", k), 72'(dp_in_valid), 72'(tbl[k].e_dpv));
      check($sformatf("tbl%0d cfg_we", k), 72'(cfg_we), 72'(tbl[k].e_we));
      if (tbl[k].e_we)
        check($sformatf("tbl%0d cfg", k), 72'({cfg_row, cfg_data}),
              72'({tbl[k].e_row, tbl[k].e_cfg}));
      check($sformatf("tbl%0d m_tvalid", k), 72'(m_tvalid), 72'(tbl[k].e_mv));
      if (tbl[k].e_mv)
        check($sformatf("tbl%0d result", k), 72'({m_tlast, m_tdata}),
              72'({tbl[k].e_ml, tbl[k].e_md}));
      check($sformatf("tbl%0d busy", k), 72'(busy), 72'(tbl[k].e_busy));
      check($sformatf("tbl%0d vec_count", k), 72'(vec_count), 72'(tbl[k].e_vc));
    end
    check("cfg_hold lane3", 72'(lane_slice(cfg_data, 3)), 72'(16'hBB33));

    // Truncated header: second beat carries tlast, then a full header follows.
    drive(1, 0, HA, 1);
    check("hdr A s_tready", 72'(s_tready), 72'(1));
    drive(1, 1, HB, 1);
    check("hdr A write", 72'({cfg_we, cfg_row, cfg_data}), 72'({1'b1, 2'd0, HA}));
    check("hdr err before", 72'(err_hdr), 72'(0));
    drive(1, 0, HC, 1);
    check("hdr B dropped", 72'(cfg_we), 72'(0));
    check("hdr err set", 72'(err_hdr), 72'(1));
    drive(1, 0, HD, 1);
    check("hdr C row0", 72'({cfg_we, cfg_row, cfg_data}), 72'({1'b1, 2'd0, HC}));
    drive(1, 0, HE, 1);
    check("hdr D row1", 72'({cfg_we, cfg_row, cfg_data}), 72'({1'b1, 2'd1, HD}));
    drive(0, 0, '0, 1);
    check("hdr E row2", 72'({cfg_we, cfg_row, cfg_data}), 72'({1'b1, 2'd2, HE}));
    check("hdr run busy", 72'(busy), 72'(1));
    check("hdr err sticky", 72'(err_hdr), 72'(1));

    // Output backpressure stalls the pipeline and holds the result.
    drive(1, 0, W0, 1);
    check("stall W0 accept", 72'({s_tready, dp_in_valid}), 72'(2'b11));
    for (int k = 0; k < 3; k++) drive(0, 0, '0, 1);
    drive(1, 1, W1, 0);
    check("stall1 out", 72'({m_tvalid, m_tlast, m_tdata}), 72'({2'b10, ~W0}));
    check("stall1 ctl", 72'({dp_ce, s_tready, dp_in_valid}), 72'(3'b000));
    drive(1, 1, W1, 0);
    check("stall2 out", 72'({m_tvalid, m_tdata}), 72'({1'b1, ~W0}));
    check("stall2 ctl", 72'({dp_ce, s_tready}), 72'(2'b00));
    check("stall2 vec_count", 72'(vec_count), 72'(1));
    drive(1, 1, W1, 1);
    check("release ctl", 72'({dp_ce, s_tready, dp_in_valid}), 72'(3'b111));
    check("release out", 72'({m_tvalid, m_tdata}), 72'({1'b1, ~W0}));
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, '0, 1);
      check($sformatf("no dup %0d", k), 72'(m_tvalid), 72'(0));
    end
    drive(0, 0, '0, 1);
    check("W1 out", 72'({m_tvalid, m_tlast, m_tdata}), 72'({2'b11, ~W1}));
    check("W1 drain ready", 72'(s_tready), 72'(0));
    drive(0, 0, '0, 1);
    check("after drain", 72'({s_tready, m_tvalid, busy}), 72'(3'b100));
    check("after drain vec_count", 72'(vec_count), 72'(2));

    // Asynchronous reset with two vectors in flight.
    drive(1, 0, H0, 1);
    drive(1, 0, H1, 1);
    drive(1, 0, H2, 1);
    drive(1, 0, vec(7), 1);
    drive(1, 0, vec(8), 0);
    drive(0, 0, '0, 0);
    drive(0, 0, '0, 0);
    drive(0, 0, '0, 0);
    check("pre-reset m_tvalid", 72'(m_tvalid), 72'(1));
    check("pre-reset vec_count", 72'(vec_count), 72'(2));
    #1 rst_n = 1'b0;
    #1;
    check("mid reset m_tvalid", 72'(m_tvalid), 72'(0));
    check("mid reset busy", 72'(busy), 72'(0));
    check("mid reset vec_count", 72'(vec_count), 72'(0));
    check("mid reset err_hdr", 72'(err_hdr), 72'(0));
    check("mid reset s_tready", 72'(s_tready), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized frames, including truncated headers, against the frame-level model.
    exp_err = 1'b0;
    exp_vc  = 0;
    for (int f = 0; f < 24; f++) begin
      bad = (f == 2) || (f == 5) || ($urandom_range(0, 4) == 0);
      if (bad) begin
        k_hdr = (f == 2) ? 2 : (f == 5) ? 3 : int'($urandom_range(1, 3));
        for (int j = 0; j < k_hdr; j++) begin
          d = {$urandom, $urandom};
          beats.push_back('{data: d, last: (j == k_hdr - 1), is_vec: 1'b0});
          if (j < k_hdr - 1) exp_cfg.push_back('{row: 2'(j), data: d});
        end
        exp_err = 1'b1;
      end else begin
        for (int j = 0; j < 3; j++) begin
          d = {$urandom, $urandom};
          beats.push_back('{data: d, last: 1'b0, is_vec: 1'b0});
          exp_cfg.push_back('{row: 2'(j), data: d});
        end
        n_vec = int'($urandom_range(1, 8));
        for (int j = 0; j < n_vec; j++) begin
          d = {16'd1, 16'($urandom), 16'($urandom), 16'($urandom)};
          beats.push_back('{data: d, last: (j == n_vec - 1), is_vec: 1'b1});
          exp_res.push_back({(j == n_vec - 1), ~d});
        end
        exp_vc = n_vec;
      end
    end

    mon_en = 1'b1;
    cyc = 0;
    while ((beats.size() != 0 || exp_res.size() != 0 || exp_cfg.size() != 0) &&
           cyc < int'(MaxCycles)) begin
      @(negedge clk);
      if (beats.size() != 0 && $urandom_range(0, 3) != 0) begin
        s_tvalid   = 1'b1;
        s_tdata    = beats[0].data;
        s_tlast    = beats[0].last;
        drv_is_vec = beats[0].is_vec;
      end else begin
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        drv_is_vec = 1'b0;
      end
      m_tready = ($urandom_range(0, 3) != 0);
      #2;
      if (s_tvalid && s_tready) void'(beats.pop_front());
      cyc++;
    end
    check("random within budget", 72'(cyc < int'(MaxCycles)), 72'(1));
    drv_is_vec = 1'b0;
    for (int k = 0; k < 6; k++) drive(0, 0, '0, 1);
    check("random busy idle", 72'(busy), 72'(0));
    check("random err_hdr", 72'(err_hdr), 72'(exp_err));
    check("random vec_count", 72'(vec_count), 72'(exp_vc));
    check("random results left", 72'(exp_res.size()), 72'(0));
    check("random inflight", 72'(outstanding), 72'(0));
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xform_stream_ctrl.md
Name: xform_stream_ctrl

Overview:
Sequencer for the 4-lane affine-transform datapath.
- Parses each incoming AXI-Stream frame. The first MAT_ROWS beats are the q16 matrix rows; every following beat is a homogeneous vector (x,y,z,1) until tlast.
- Loads the rows into the datapath coefficient bank, gates vectors into the datapath pipeline, and tracks valid/last alignment through PIPE_LAT stages.
- Applies output backpressure as a global pipeline stall. Sits between the s00 AXIS slave and the datapath/m00 master inside the top.

Parameters:
DATA_WIDTH, 16, input lane width (q16 coefficients and vector elements)
OUT_WIDTH, 16, output lane width
LANES, 4, lanes per beat
MAT_ROWS, 3, header beats (matrix rows) per frame
PIPE_LAT, 4, datapath latency in enabled cycles, must be >= 1
CNT_WIDTH, 16, width of vec_count

Ports:
s00_axis_aclk  in  1  single clock
s00_axis_aresetn  in  1  asynchronous active-low reset
s_tdata  in  LANES*DATA_WIDTH  input beat
s_tvalid  in  1  input valid
s_tready  out  1  input ready
s_tlast  in  1  end of frame
cfg_we  out  1  coefficient row write strobe
cfg_row  out  2  coefficient row index 0..MAT_ROWS-1
cfg_data  out  LANES*DATA_WIDTH  coefficient row data
dp_ce  out  1  datapath clock enable (global stall when 0)
dp_in_valid  out  1  vector presented to datapath this cycle
dp_in_data  out  LANES*DATA_WIDTH  vector to datapath (= s_tdata)
dp_out_data  in  LANES*OUT_WIDTH  datapath result
m_tdata  out  LANES*OUT_WIDTH  result (= dp_out_data)
m_tvalid  out  1  result valid
m_tready  in  1  downstream ready (tie 1 if unused)
m_tlast  out  1  last result of frame
busy  out  1  state != MAT or pipeline non-empty
err_hdr  out  1  sticky: tlast seen during header
vec_count  out  CNT_WIDTH  vectors accepted in current frame

Behaviour:
- Reset (async, aresetn=0) forces the following:
  - state = MAT, row_cnt = 0.
  - vld/last shift registers = 0.
  - cfg_we = 0, cfg_row = 0, cfg_data = 0.
  - err_hdr = 0, vec_count = 0, m_tvalid = 0, m_tlast = 0.
  - s_tready = 0 while reset is asserted.
- dp_ce = m_tready | ~vld[PIPE_LAT-1]. When dp_ce = 0, the vld/last registers and the datapath hold.
- Accept = s_tvalid & s_tready.
- State MAT:
  - s_tready = 1.
  - On accept: cfg_data <= s_tdata, cfg_row <= row_cnt, cfg_we <= 1 for exactly one cycle (registered, 1-cycle latency), then row_cnt++.
  - When the accepted beat has row_cnt = MAT_ROWS-1: row_cnt <= 0, vec_count <= 0, state <= RUN.
  - tlast on a header beat: err_hdr <= 1, row_cnt <= 0, stay MAT. The partial header is discarded but rows already written are not rolled back.
- State RUN:
  - s_tready = dp_ce; dp_in_valid = accept.
  - Each dp_ce cycle shifts vld/last: vld[0] <= accept, last[0] <= accept & s_tlast.
  - On accept: vec_count++ (saturates at all-ones).
  - Accept with tlast: state <= DRAIN.
- State DRAIN:
  - s_tready = 0; the pipeline continues shifting with 0 injected.
  - When all vld bits are 0 (including the cycle the final result is taken), state <= MAT.
  - No coefficient write may occur while any in-flight vector is present.
- Output: m_tvalid = vld[PIPE_LAT-1], m_tlast = last[PIPE_LAT-1].
- Latency: a vector accepted at cycle t appears at t+PIPE_LAT with no stalls, and at t+PIPE_LAT+(stall cycles) otherwise.
- A result is held stable while m_tvalid & ~m_tready.
- Back-to-back frames: the first header beat of the next frame is accepted at the earliest one cycle after the pipeline empties.
- Zero-vector frame (tlast on the beat after the header is impossible by this definition): the first RUN beat with tlast produces one result with m_tlast = 1.
- busy = (state != MAT) | (|vld).

Decomposition:
- Package xform_pkg: state enum {MAT, RUN, DRAIN}, default widths, MAT_ROWS constant, lane slice helper.
- One natural sub-module: xform_tag_pipe (PIPE_LAT-deep valid/last shift register with enable).

Test Plan:
1. Header rows {41,0,0,-20480}, {0,41,0,-16384}, {0,0,41,-17613} back-to-back -> cfg_we pulses 3 consecutive cycles, cfg_row 0,1,2, cfg_data exact. State RUN after the 3rd beat.
2. 5 vectors, tlast on the 5th, m_tready = 1 -> 5 results at accept+PIPE_LAT. m_tlast only on the 5th. vec_count = 5. s_tready low in DRAIN, high again one cycle after vld is empty.
3. 11 vectors with tlast on index 4 -> beats 5..7 become cfg rows 0..2 (cfg_we seen only after the pipeline drains). Beats 8..10 are processed as vectors.
4. m_tready toggles 1,0,0,1 during streaming -> dp_ce follows. No result dropped or duplicated. s_tready low during stall. m_tdata stable while stalled.
5. tlast asserted on header beat 2 -> err_hdr = 1 (sticky), row_cnt back to 0. The next 3 beats form a full header.
6. aresetn deasserted mid-RUN with 2 in flight -> m_tvalid = 0 immediately, state MAT, vec_count = 0, err_hdr = 0.
